// File: rtl/cpi_monitor_ctrl.sv
// cpi_monitor_ctrl
// Measures cycles and retired instructions between a start command and a
// processor halt, then runs a restoring shift-subtract divider to produce
// CPI as an unsigned fixed-point value with FRAC_W fractional bits.
// Results are held in DONE until cleared or re-armed.
module cpi_monitor_ctrl #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic                      i_clear,
    input  logic                      i_instr_retire,
    input  logic                      i_processor_hlt,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [CNT_W-1:0]          o_cycles,
    output logic [CNT_W-1:0]          o_instrs,
    output logic [CNT_W+FRAC_W-1:0]   o_cpi,
    output logic                      o_div_zero,
    output logic                      o_ovf
);

    localparam int Q_W  = CNT_W + FRAC_W;
    localparam int BC_W = $clog2(Q_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [Q_W-1:0]   Q_ZERO   = {Q_W{1'b0}};
    localparam logic [Q_W-1:0]   Q_ONES   = {Q_W{1'b1}};
    localparam logic [BC_W-1:0]  BC_ZERO  = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]  BC_ONE   = {{(BC_W-1){1'b0}}, 1'b1};
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(Q_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cycles_q,  cycles_d;
    logic [CNT_W-1:0]  instrs_q,  instrs_d;
    logic [Q_W-1:0]    cpi_q,     cpi_d;
    logic              valid_q,   valid_d;
    logic              dz_q,      dz_d;
    logic              ovf_q,     ovf_d;
    // Divider working set: remainder stays below the divisor, so CNT_W bits
    // hold it between steps; the shifted trial value needs one extra bit.
    logic [CNT_W-1:0]  rem_q,     rem_d;
    logic [Q_W-1:0]    dvd_q,     dvd_d;
    logic [Q_W-1:0]    quo_q,     quo_d;
    logic [BC_W-1:0]   bcnt_q,    bcnt_d;

    logic              cyc_max_s;
    logic              ins_max_s;
    logic [CNT_W-1:0]  cyc_inc_s;
    logic [CNT_W-1:0]  ins_inc_s;
    logic [CNT_W:0]    rem_sh_s;
    logic [CNT_W:0]    rem_sub_s;
    logic              qbit_s;
    logic [Q_W-1:0]    quo_nxt_s;

    assign cyc_max_s = (cycles_q == CNT_MAX);
    assign ins_max_s = (instrs_q == CNT_MAX);
    assign cyc_inc_s = cyc_max_s ? cycles_q : (cycles_q + CNT_ONE);
    assign ins_inc_s = ins_max_s ? instrs_q : (instrs_q + CNT_ONE);

    // One restoring-division step: shift in the next dividend bit, try subtract.
    assign rem_sh_s  = {rem_q, dvd_q[Q_W-1]};
    assign qbit_s    = (rem_sh_s >= {1'b0, instrs_q});
    assign rem_sub_s = rem_sh_s - {1'b0, instrs_q};
    assign quo_nxt_s = {quo_q[Q_W-2:0], qbit_s};

    assign o_busy     = (state_q == ST_COUNT) || (state_q == ST_DIVIDE);
    assign o_valid    = valid_q;
    assign o_cycles   = cycles_q;
    assign o_instrs   = instrs_q;
    assign o_cpi      = cpi_q;
    assign o_div_zero = dz_q;
    assign o_ovf      = ovf_q;

    // Next-state and datapath update, priority clear > start > halt > retire.
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        instrs_d = instrs_q;
        cpi_d    = cpi_q;
        valid_d  = valid_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        bcnt_d   = bcnt_q;

        if (i_clear) begin
            state_d  = ST_IDLE;
            cycles_d = CNT_ZERO;
            instrs_d = CNT_ZERO;
            cpi_d    = Q_ZERO;
            valid_d  = 1'b0;
            dz_d     = 1'b0;
            ovf_d    = 1'b0;
            rem_d    = CNT_ZERO;
            dvd_d    = Q_ZERO;
            quo_d    = Q_ZERO;
            bcnt_d   = BC_ZERO;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_d  = ST_COUNT;
                        cycles_d = CNT_ZERO;
                        instrs_d = CNT_ZERO;
                        cpi_d    = Q_ZERO;
                        valid_d  = 1'b0;
                        dz_d     = 1'b0;
                        ovf_d    = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_COUNT: begin
                    if (i_start) begin
                        // Restart: the restart edge itself is not counted and
                        // saturation history from the aborted run is dropped.
                        cycles_d = CNT_ZERO;
                        instrs_d = CNT_ZERO;
                        ovf_d    = 1'b0;
                    end else begin
                        cycles_d = cyc_inc_s;
                        if (cyc_max_s) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_q;
                        end
                        if (i_instr_retire) begin
                            instrs_d = ins_inc_s;
                            if (ins_max_s) begin
                                ovf_d = 1'b1;
                            end else begin
                                instrs_d = ins_inc_s;
                            end
                        end else begin
                            instrs_d = instrs_q;
                        end
                        if (i_processor_hlt) begin
                            // Load the divider with the final (post-increment) count.
                            state_d = ST_DIVIDE;
                            dvd_d   = {cyc_inc_s, {FRAC_W{1'b0}}};
                            rem_d   = CNT_ZERO;
                            quo_d   = Q_ZERO;
                            bcnt_d  = BC_ZERO;
                        end else begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (instrs_q == CNT_ZERO) begin
                        state_d = ST_DONE;
                        cpi_d   = Q_ONES;
                        dz_d    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        if (qbit_s) begin
                            rem_d = rem_sub_s[CNT_W-1:0];
                        end else begin
                            rem_d = rem_sh_s[CNT_W-1:0];
                        end
                        dvd_d = {dvd_q[Q_W-2:0], 1'b0};
                        quo_d = quo_nxt_s;
                        if (bcnt_q == BC_LAST) begin
                            state_d = ST_DONE;
                            cpi_d   = quo_nxt_s;
                            valid_d = 1'b1;
                            bcnt_d  = BC_ZERO;
                        end else begin
                            bcnt_d = bcnt_q + BC_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cycles_q <= CNT_ZERO;
            instrs_q <= CNT_ZERO;
            cpi_q    <= Q_ZERO;
            valid_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= CNT_ZERO;
            dvd_q    <= Q_ZERO;
            quo_q    <= Q_ZERO;
            bcnt_q   <= BC_ZERO;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            instrs_q <= instrs_d;
            cpi_q    <= cpi_d;
            valid_q  <= valid_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            bcnt_q   <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_cpi_monitor_ctrl.sv
// Directed testbench for cpi_monitor_ctrl with hand-computed expectations.
module tb_cpi_monitor_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_clear;
    logic        i_instr_retire;
    logic        i_processor_hlt;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_cycles;
    logic [15:0] o_instrs;
    logic [23:0] o_cpi;
    logic        o_div_zero;
    logic        o_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    cpi_monitor_ctrl #(.CNT_W(16), .FRAC_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_clear         (i_clear),
        .i_instr_retire  (i_instr_retire),
        .i_processor_hlt (i_processor_hlt),
        .o_busy          (o_busy),
        .o_valid         (o_valid),
        .o_cycles        (o_cycles),
        .o_instrs        (o_instrs),
        .o_cpi           (o_cpi),
        .o_div_zero      (o_div_zero),
        .o_ovf           (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs set beforehand are sampled there, outputs read 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arm, then cyc COUNT edges with halt on the last; retires on the last ret edges.
    task automatic run_count(input int cyc, input int ret, input string tag);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_eq({tag, "_arm_valid"},  32'(o_valid),  32'd0);
        check_eq({tag, "_arm_cycles"}, 32'(o_cycles), 32'd0);
        check_eq({tag, "_arm_busy"},   32'(o_busy),   32'd1);
        for (int i = 1; i <= cyc; i++) begin
            i_instr_retire  = (i > cyc - ret);
            i_processor_hlt = (i == cyc);
            step();
        end
        i_instr_retire  = 1'b0;
        i_processor_hlt = 1'b0;
    endtask

    task automatic wait_valid(input int n0, output int n);
        n = n0;
        while (!o_valid && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic check_res(input string tag, input int cyc, input int ins, input int cpi,
                             input int dz, input int ovf);
        check_eq({tag, "_cycles"}, 32'(o_cycles),   32'(cyc));
        check_eq({tag, "_instrs"}, 32'(o_instrs),   32'(ins));
        check_eq({tag, "_cpi"},    32'(o_cpi),      32'(cpi));
        check_eq({tag, "_dz"},     32'(o_div_zero), 32'(dz));
        check_eq({tag, "_ovf"},    32'(o_ovf),      32'(ovf));
        check_eq({tag, "_valid"},  32'(o_valid),    32'd1);
        check_eq({tag, "_busy"},   32'(o_busy),     32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"},  32'(o_busy),  32'd0);
        check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_outs"},
                 32'(o_cycles) | 32'(o_instrs) | 32'(o_cpi) | 32'(o_div_zero) | 32'(o_ovf),
                 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        i_start = 1'b0;
        i_clear = 1'b0;
        i_instr_retire = 1'b0;
        i_processor_hlt = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_zero("reset");

        // Basic 100 cycles / 50 instrs -> CPI 2.0
        run_count(100, 50, "basic");
        check_eq("basic_busy_div", 32'(o_busy), 32'd1);
        for (int i = 0; i < 12; i++) step();
        check_eq("basic_no_partial_cpi", 32'(o_cpi), 32'd0);
        check_eq("basic_mid_valid", 32'(o_valid), 32'd0);
        wait_valid(12, lat);
        check_eq("basic_latency", 32'(lat), 32'd24);
        check_res("basic", 100, 50, 24'h000200, 0, 0);
        step();
        step();
        check_eq("basic_hold_valid", 32'(o_valid), 32'd1);
        check_eq("basic_hold_cpi", 32'(o_cpi), 32'h200);

        // Re-arm from DONE, fractional 10/3 -> 853
        run_count(10, 3, "frac");
        wait_valid(0, lat);
        check_eq("frac_latency", 32'(lat), 32'd24);
        check_res("frac", 10, 3, 24'h000355, 0, 0);

        run_count(7, 7, "unity");
        wait_valid(0, lat);
        check_res("unity", 7, 7, 24'h000100, 0, 0);

        // Divide by zero
        run_count(5, 0, "dz");
        wait_valid(0, lat);
        check_eq("dz_latency", 32'(lat), 32'd1);
        check_res("dz", 5, 0, 24'hFFFFFF, 1, 0);

        // Retire on the halt edge counted (all 4 edges retire, incl. halt)
        run_count(4, 4, "hlt_ret");
        wait_valid(0, lat);
        check_res("hlt_ret", 4, 4, 24'h000100, 0, 0);

        // Start and halt on the same COUNT edge -> restart
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        i_start = 1'b1;
        i_processor_hlt = 1'b1;
        i_instr_retire = 1'b1;
        step();
        i_start = 1'b0;
        i_processor_hlt = 1'b0;
        i_instr_retire = 1'b0;
        check_eq("restart_busy", 32'(o_busy), 32'd1);
        check_eq("restart_cycles", 32'(o_cycles), 32'd0);
        check_eq("restart_instrs", 32'(o_instrs), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check_eq("restart_counting", 32'(o_cycles), 32'd3);
        i_processor_hlt = 1'b1;
        step();
        i_processor_hlt = 1'b0;
        wait_valid(0, lat);
        check_eq("restart_latency", 32'(lat), 32'd1);
        check_res("restart", 4, 0, 24'hFFFFFF, 1, 0);

        // i_start in DIVIDE ignored
        run_count(10, 3, "startdiv");
        for (int i = 0; i < 5; i++) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_valid(6, lat);
        check_eq("startdiv_latency", 32'(lat), 32'd24);
        check_res("startdiv", 10, 3, 24'h000355, 0, 0);

        // Reset mid-DIVIDE
        run_count(100, 50, "rstdiv");
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_zero("rstdiv");
        for (int i = 0; i < 30; i++) step();
        check_zero("rstdiv_idle");

        // Clear mid-COUNT, then IDLE ignores halt/retire
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_instr_retire = 1'b1;
        for (int i = 0; i < 10; i++) step();
        i_instr_retire = 1'b0;
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check_zero("clear");
        i_processor_hlt = 1'b1;
        i_instr_retire = 1'b1;
        step();
        step();
        i_processor_hlt = 1'b0;
        i_instr_retire = 1'b0;
        check_zero("idle_ignore");

        // Saturation: 70000 cycles, 256 retires -> 0xFFFF00/256 = 0xFFFF
        run_count(70000, 256, "sat");
        wait_valid(0, lat);
        check_eq("sat_latency", 32'(lat), 32'd24);
        check_res("sat", 16'hFFFF, 256, 24'h00FFFF, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
